// File: rtl/prog_loader.sv
// Serial program loader: parses SYNC, N, N data bytes, checksum from the UART byte
// stream and writes the image into CPU RAM. Optional ack reply: PROG_LOADER_ACK_EN.
module prog_loader #(
   parameter int         ADDR_W         = 4,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 1200000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_din,
   output logic              cpu_halt,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   input  logic              tx_busy
);
   localparam int MAX_N = 2**ADDR_W;
   localparam int REM_W = ADDR_W + 1;
   localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, ACK} state_t;
`ifdef PROG_LOADER_ACK_EN
   localparam state_t END_ST = ACK;
`else
   localparam state_t END_ST = IDLE;
`endif

   state_t            state, state_n;
   logic [ADDR_W-1:0] addr, addr_n, ram_addr_n;
   logic [REM_W-1:0]  remaining, rem_n;
   logic [7:0]        sum, sum_n, ram_din_n;
   logic [TW-1:0]     tcnt, tcnt_n;
   logic              ram_we_n, done_n, err_n, ok, ok_n, in_frame, timeout;

   assign busy     = (state != IDLE);
   assign cpu_halt = busy;

   always_comb begin
      state_n    = state;
      addr_n     = addr;
      rem_n      = remaining;
      sum_n      = sum;
      ok_n       = ok;
      ram_we_n   = 1'b0;
      ram_addr_n = ram_addr;
      ram_din_n  = ram_din;
      done_n     = 1'b0;
      err_n      = 1'b0;
      in_frame   = (state == COUNT) || (state == DATA) || (state == CHECK);
      // a byte arriving on the expiry cycle takes priority over the timeout
      timeout    = in_frame && !rx_valid && (tcnt == TW'(TIMEOUT_CYCLES - 1));
      tcnt_n     = (rx_valid || !in_frame) ? '0 : tcnt + 1'b1;
      case (state)
         IDLE:
            if (rx_valid && rx_data == SYNC_BYTE) state_n = COUNT;
         COUNT:
            if (rx_valid) begin
               if (rx_data == 8'd0 || int'(rx_data) > MAX_N) begin
                  err_n   = 1'b1;
                  ok_n    = 1'b0;
                  state_n = END_ST;
               end else begin
                  rem_n   = REM_W'(rx_data);
                  addr_n  = '0;
                  sum_n   = '0;
                  state_n = DATA;
               end
            end
         DATA:
            if (rx_valid) begin
               ram_we_n   = 1'b1;
               ram_addr_n = addr;
               ram_din_n  = rx_data;
               sum_n      = sum + rx_data;
               addr_n     = addr + 1'b1;
               rem_n      = remaining - 1'b1;
               if (remaining == REM_W'(1)) state_n = CHECK;
            end
         CHECK:
            if (rx_valid) begin
               done_n  = (rx_data == sum);
               err_n   = (rx_data != sum);
               ok_n    = (rx_data == sum);
               state_n = END_ST;
            end
`ifdef PROG_LOADER_ACK_EN
         ACK:
            if (!tx_busy) state_n = IDLE;
`endif
         default: ;
      endcase
      if (timeout) begin
         err_n   = 1'b1;
         ok_n    = 1'b0;
         state_n = END_ST;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr      <= '0;
         remaining <= '0;
         sum       <= '0;
         tcnt      <= '0;
         ok        <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_din   <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_n;
         addr      <= addr_n;
         remaining <= rem_n;
         sum       <= sum_n;
         tcnt      <= tcnt_n;
         ok        <= ok_n;
         ram_we    <= ram_we_n;
         ram_addr  <= ram_addr_n;
         ram_din   <= ram_din_n;
         done      <= done_n;
         err       <= err_n;
      end
   end

`ifdef PROG_LOADER_ACK_EN
   logic       tx_start_n;
   logic [7:0] tx_data_n;

   always_comb begin
      tx_start_n = 1'b0;
      tx_data_n  = tx_data;
      if (state == ACK && !tx_busy) begin
         tx_start_n = 1'b1;
         tx_data_n  = ok ? 8'h06 : 8'h15;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_start <= 1'b0;
         tx_data  <= '0;
      end else begin
         tx_start <= tx_start_n;
         tx_data  <= tx_data_n;
      end
   end
`else
   logic unused;
   assign tx_start = 1'b0;
   assign tx_data  = 8'h00;
   assign unused   = tx_busy ^ ok;
`endif

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Serial program loader: consumes the received-byte stream from uart_receive and writes a framed program image into the CPU RAM.
- Holds the CPU halted while loading, and reports success or failure.
- It is the write path into the machine, opposite the DIP/seven-segment observation path.
- Sits between uart_receive and the ram write port, clocked by the board CLK.

Parameters:
- ADDR_W, 4, RAM address width; max image length is 2**ADDR_W bytes.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1200000, max clocks between bytes inside a frame (100 ms at 12 MHz).

Ports:
- clk  in  1  system clock (CLK).
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte from uart_receive.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- ram_we  out  1  RAM write enable, one-cycle pulse.
- ram_addr  out  ADDR_W  RAM write address.
- ram_din  out  8  RAM write data.
- cpu_halt  out  1  high while a frame is in progress.
- busy  out  1  same as cpu_halt.
- done  out  1  one-cycle pulse: frame accepted.
- err  out  1  one-cycle pulse: frame rejected.
- tx_data  out  8  ack byte to uart_send.
- tx_start  out  1  one-cycle start pulse to uart_send.
- tx_busy  in  1  uart_send busy.

Behaviour:
- Frame format: SYNC_BYTE, N (1..2**ADDR_W), N data bytes, checksum. Checksum = sum of the data bytes mod 256.
- Reset: async on rst_n low.
  - State goes to IDLE.
  - All outputs, counters, accumulated sum and timeout counter go to 0.
  - Applies mid-frame too. RAM writes already issued are not rolled back.
- Each rx_valid consumes exactly one byte in the current state.
- States and transitions:
  - IDLE: a byte equal to SYNC_BYTE moves to COUNT. All other bytes are ignored.
  - COUNT: the byte is N.
    - N==0 or N>2**ADDR_W: err pulse, go to IDLE (or ACK if the feature is enabled).
    - Otherwise: latch N, clear addr and sum, go to DATA.
  - DATA: for each byte:
    - Next cycle: ram_we=1, ram_addr=current addr, ram_din=byte.
    - sum += byte (8-bit wrap), addr++, remaining--.
    - When remaining reaches 0, go to CHECK.
    - With N=2**ADDR_W the last write is to the top address; addr is not used after that.
  - CHECK: next cycle after the checksum byte, done=1 if byte==sum, else err=1. Then go to IDLE (or ACK).
- Latency:
  - ram_we: 1 cycle after the rx_valid of the data byte.
  - done/err: 1 cycle after the rx_valid of the checksum byte.
- cpu_halt = busy = (state != IDLE). Both are registered and go high the cycle after the SYNC byte is accepted.
- Timeout:
  - The counter clears on every rx_valid and counts while state is COUNT, DATA or CHECK.
  - When it reaches TIMEOUT_CYCLES-1: err pulse, go to IDLE (or ACK).
  - If rx_valid lands in the same cycle as the timeout, the byte wins and the counter clears.
- A SYNC_BYTE value received inside a frame is treated as ordinary data or count; no resync.
- done and err are never high together.
- ram_we is never high outside DATA byte writes.

Optional Feature:
- Macro: PROG_LOADER_ACK_EN.
- Defined:
  - Every frame outcome (done, err, timeout) enters state ACK; busy stays high.
  - ACK waits for tx_busy==0, then pulses tx_start for 1 cycle with tx_data = 8'h06 (ok) or 8'h15 (fail), then goes to IDLE.
  - rx bytes received during ACK are ignored.
- Undefined:
  - No ACK state; outcomes go straight to IDLE.
  - tx_start and tx_data are held at 0; tx_busy is ignored.

Test Plan:
- Send A5,03,10,20,30,60 -> writes (0,10),(1,20),(2,30); done pulse; cpu_halt high from the cycle after A5 until IDLE; err never high.
- Send A5,02,01,02,FF -> two writes; err pulse (expected sum 03); no done; with ACK_EN, tx_data=15 and one tx_start.
- Send A5,00 and A5,11 -> err pulse each time, no ram_we, back to IDLE; a following valid frame still loads.
- Send A5,10 then 16 bytes 00..0F, then 78 -> writes to addresses 0..F; done pulse.
- Send A5,02,AA, then idle for TIMEOUT_CYCLES (use 100 in sim) -> err pulse, busy low, one write only; a subsequent valid frame loads.
- Assert rst_n low in mid-DATA -> outputs 0 immediately; after release, 55 is ignored in IDLE and A5,01,07,07 gives a done pulse.
